// File: rtl/rc5_key_sched_ctrl_if.sv
// Handshake and L RAM write-port bundle for the RC5 key-schedule controller.
// slave = the controller; master = the engines/environment that drive it.
interface rc5_key_sched_ctrl_if #(
    parameter int W = 32,
    parameter int C = 4
);
    localparam int C_LENGTH = $clog2(C);

    logic                start;
    logic                ready;
    logic                done;
    logic [2:0]          phase;
    logic                l_start;
    logic                s_start;
    logic                mix_start;
    logic                l_done;
    logic                s_done;
    logic                mix_done;
    logic [C_LENGTH-1:0] l_op_addr;
    logic [W-1:0]        l_op_data;
    logic                l_op_we;
    logic [C_LENGTH-1:0] mix_addr;
    logic [W-1:0]        mix_data;
    logic                mix_we;
    logic [C_LENGTH-1:0] lram_addr;
    logic [W-1:0]        lram_data;
    logic                lram_we;
    logic                timeout_err;

    modport slave (
        input  start, l_done, s_done, mix_done,
        input  l_op_addr, l_op_data, l_op_we, mix_addr, mix_data, mix_we,
        output ready, done, phase, l_start, s_start, mix_start,
        output lram_addr, lram_data, lram_we, timeout_err
    );

    modport master (
        output start, l_done, s_done, mix_done,
        output l_op_addr, l_op_data, l_op_we, mix_addr, mix_data, mix_we,
        input  ready, done, phase, l_start, s_start, mix_start,
        input  lram_addr, lram_data, lram_we, timeout_err
    );
endinterface

// File: rtl/rc5_key_sched_ctrl.sv
// Sequences the RC5 L-conversion, S-init and mixing engines and arbitrates L RAM port A.
// Optional per-phase watchdog: define RC5_KEY_SCHED_TIMEOUT_EN.
module rc5_key_sched_ctrl #(
    parameter int W       = 32,
    parameter int C       = 4,
    parameter int TIMEOUT = 1023
) (
    input logic               clk,
    input logic               rst,
    rc5_key_sched_ctrl_if.slave bus
);
    localparam int C_LENGTH = $clog2(C);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        L_RUN   = 3'd1,
        S_RUN   = 3'd2,
        MIX_RUN = 3'd3,
        FINISH  = 3'd4
    } state_e;

    state_e state_q;
    logic   l_start_q, s_start_q, mix_start_q, done_q;
    logic   own_done, launch, adv, accept, expired;

    logic                lram_we_d;
    logic [C_LENGTH-1:0] lram_addr_d;
    logic [W-1:0]        lram_data_d;

    // The launch-pulse cycle is exactly when the engine's done must be ignored.
    assign launch = l_start_q | s_start_q | mix_start_q;
    assign accept = (state_q == IDLE) && bus.start;

    always_comb begin
        own_done = 1'b0;
        case (state_q)
            L_RUN:   own_done = bus.l_done;
            S_RUN:   own_done = bus.s_done;
            MIX_RUN: own_done = bus.mix_done;
            default: own_done = 1'b0;
        endcase
    end

    assign adv = own_done && !launch;

`ifdef RC5_KEY_SCHED_TIMEOUT_EN
    localparam int             WDW     = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    logic [WDW-1:0] wd_q;
    logic           tmo_q;
    logic           running;

    assign running = (state_q == L_RUN) || (state_q == S_RUN) || (state_q == MIX_RUN);
    assign expired = running && (wd_q == WD_LAST);

    // wd_q reads 0 in the first cycle of a phase, so the phase lasts TIMEOUT cycles at most.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q  <= '0;
            tmo_q <= 1'b0;
        end else begin
            if (accept || adv || !running) wd_q <= '0;
            else                           wd_q <= wd_q + 1'b1;
            if (accept)                    tmo_q <= 1'b0;
            else if (expired && !adv)      tmo_q <= 1'b1;
        end
    end

    assign bus.timeout_err = tmo_q;
`else
    // No watchdog in this build; the flag is constant low for any legal TIMEOUT.
    assign expired         = 1'b0;
    assign bus.timeout_err = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            l_start_q   <= 1'b0;
            s_start_q   <= 1'b0;
            mix_start_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            l_start_q   <= 1'b0;
            s_start_q   <= 1'b0;
            mix_start_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    state_q   <= L_RUN;
                    l_start_q <= 1'b1;
                end
                L_RUN: if (adv) begin
                    state_q   <= S_RUN;
                    s_start_q <= 1'b1;
                end else if (expired) state_q <= IDLE;
                S_RUN: if (adv) begin
                    state_q     <= MIX_RUN;
                    mix_start_q <= 1'b1;
                end else if (expired) state_q <= IDLE;
                MIX_RUN: if (adv) begin
                    state_q <= FINISH;
                    done_q  <= 1'b1;
                end else if (expired) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Only the phase owner reaches the RAM; everyone else is masked to zero.
    always_comb begin
        lram_we_d   = 1'b0;
        lram_addr_d = '0;
        lram_data_d = '0;
        if (state_q == L_RUN) begin
            lram_we_d   = bus.l_op_we;
            lram_addr_d = bus.l_op_addr;
            lram_data_d = bus.l_op_data;
        end else if (state_q == MIX_RUN) begin
            lram_we_d   = bus.mix_we;
            lram_addr_d = bus.mix_addr;
            lram_data_d = bus.mix_data;
        end
    end

    assign bus.lram_we   = lram_we_d;
    assign bus.lram_addr = lram_addr_d;
    assign bus.lram_data = lram_data_d;

    assign bus.ready     = (state_q == IDLE);
    assign bus.done      = done_q;
    assign bus.phase     = state_q;
    assign bus.l_start   = l_start_q;
    assign bus.s_start   = s_start_q;
    assign bus.mix_start = mix_start_q;
endmodule

// File: tb/tb_rc5_key_sched_ctrl.sv
// Directed bench for rc5_key_sched_ctrl: sequencing, arbitration, stray inputs, reset, watchdog.
module tb_rc5_key_sched_ctrl;
    localparam int W   = 32;
    localparam int C   = 4;
    localparam int TMO = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0, errors = 0;
    int   cyc = 0, done_cnt = 0, ls_cnt = 0, ss_cnt = 0, ms_cnt = 0;
    logic [W-1:0] ram [C];
    logic ram_init = 1'b0;

    rc5_key_sched_ctrl_if #(.W(W), .C(C)) ifc ();
    rc5_key_sched_ctrl #(.W(W), .C(C), .TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(ifc));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < C; i++) ram[i] <= 32'h1000_0000 + 32'(i);
        end else if (ifc.lram_we) begin
            ram[ifc.lram_addr] <= ifc.lram_data;
        end
    end

    always @(negedge clk) begin
        if (ifc.done)      done_cnt++;
        if (ifc.l_start)   ls_cnt++;
        if (ifc.s_start)   ss_cnt++;
        if (ifc.mix_start) ms_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic launch_of(input int ph);
        case (ph)
            1:       return ifc.l_start;
            2:       return ifc.s_start;
            default: return ifc.mix_start;
        endcase
    endfunction

    task automatic set_done(input int ph, input logic v);
        case (ph)
            1:       ifc.l_done   = v;
            2:       ifc.s_done   = v;
            default: ifc.mix_done = v;
        endcase
    endtask

    task automatic start_run();
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
    endtask

    // Entered on the launch cycle; engine answers dly cycles after its launch.
    task automatic do_phase(input int ph, input int dly);
        chk($sformatf("phase_%0d", ph), 32'(ifc.phase), 32'(ph));
        chk($sformatf("launch_%0d", ph), 32'(launch_of(ph)), 32'd1);
        for (int i = 0; i < dly; i++) tick();
        chk($sformatf("launch_low_%0d", ph), 32'(launch_of(ph)), 32'd0);
        set_done(ph, 1'b1);
        tick();
        set_done(ph, 1'b0);
    endtask

    int c0, d0, l0, s0, m0;

    initial begin
        ifc.start = 0; ifc.l_done = 0; ifc.s_done = 0; ifc.mix_done = 0;
        ifc.l_op_we = 1; ifc.l_op_addr = 2'd3; ifc.l_op_data = 32'hDEAD_BEEF;
        ifc.mix_we = 1;  ifc.mix_addr = 2'd1;  ifc.mix_data = 32'hCAFE_F00D;

        // Reset state, with write requests present to prove they are masked in IDLE
        tick(); tick();
        chk("rst_ready", 32'(ifc.ready), 1);
        chk("rst_done", 32'(ifc.done), 0);
        chk("rst_phase", 32'(ifc.phase), 0);
        chk("rst_launch", 32'({ifc.l_start, ifc.s_start, ifc.mix_start}), 0);
        chk("rst_lram_we", 32'(ifc.lram_we), 0);
        chk("rst_lram_addr", 32'(ifc.lram_addr), 0);
        chk("rst_lram_data", ifc.lram_data, 0);
        chk("rst_tmo", 32'(ifc.timeout_err), 0);
        rst = 0;
        ifc.l_op_we = 0; ifc.mix_we = 0;
        tick();
        chk("idle_hold", 32'(ifc.phase), 0);

        // Nominal run, each engine answers 3 cycles after its launch
        d0 = done_cnt; l0 = ls_cnt; s0 = ss_cnt; m0 = ms_cnt;
        start_run();
        do_phase(1, 3); do_phase(2, 3); do_phase(3, 3);
        chk("nom_finish_phase", 32'(ifc.phase), 4);
        chk("nom_finish_done", 32'(ifc.done), 1);
        chk("nom_finish_ready", 32'(ifc.ready), 0);
        tick();
        chk("nom_back_idle", 32'(ifc.phase), 0);
        chk("nom_ready", 32'(ifc.ready), 1);
        chk("nom_done_low", 32'(ifc.done), 0);
        chk("nom_done_cnt", 32'(done_cnt - d0), 1);
        chk("nom_l_width", 32'(ls_cnt - l0), 1);
        chk("nom_s_width", 32'(ss_cnt - s0), 1);
        chk("nom_m_width", 32'(ms_cnt - m0), 1);

        // Minimum latency: 7 cycles start-edge to done
        c0 = cyc;
        start_run();
        do_phase(1, 1); do_phase(2, 1); do_phase(3, 1);
        chk("lat_done", 32'(ifc.done), 1);
        chk("lat_cycles", 32'(cyc - c0), 7);
        tick();

        // Arbitration
        ram_init = 1; tick(); ram_init = 0;
        start_run();
        ifc.l_op_we = 1; ifc.l_op_addr = 2'd2; ifc.l_op_data = 32'hFFFE_EEE5;
        ifc.mix_we = 1;  ifc.mix_addr = 2'd1;  ifc.mix_data = 32'h1234_5678;
        #1;
        chk("arbL_we", 32'(ifc.lram_we), 1);
        chk("arbL_addr", 32'(ifc.lram_addr), 2);
        chk("arbL_data", ifc.lram_data, 32'hFFFE_EEE5);
        tick();
        ifc.l_op_we = 0; ifc.mix_we = 0;
        chk("arbL_ram2", ram[2], 32'hFFFE_EEE5);
        chk("arbL_ram1", ram[1], 32'h1000_0001);
        ifc.l_done = 1; tick(); ifc.l_done = 0;
        ifc.l_op_we = 1; ifc.mix_we = 1;
        #1;
        chk("arbS_we", 32'(ifc.lram_we), 0);
        chk("arbS_addr", 32'(ifc.lram_addr), 0);
        chk("arbS_data", ifc.lram_data, 0);
        tick();
        ifc.l_op_we = 0; ifc.mix_we = 0;
        ifc.s_done = 1; tick(); ifc.s_done = 0;
        ifc.mix_we = 1;  ifc.mix_addr = 2'd3;  ifc.mix_data = 32'hA5A5_0003;
        ifc.l_op_we = 1; ifc.l_op_addr = 2'd0; ifc.l_op_data = 32'h0BAD_0000;
        #1;
        chk("arbM_addr", 32'(ifc.lram_addr), 3);
        tick();
        ifc.l_op_we = 0; ifc.mix_we = 0;
        chk("arbM_ram3", ram[3], 32'hA5A5_0003);
        chk("arbM_ram0", ram[0], 32'h1000_0000);
        chk("arbM_ram1", ram[1], 32'h1000_0001);
        ifc.mix_done = 1; tick(); ifc.mix_done = 0;
        tick();

        // Stray inputs; simultaneous l_done and mix_done counts as l_done
        l0 = ls_cnt; s0 = ss_cnt;
        start_run();
        tick();
        ifc.mix_done = 1; ifc.s_done = 1;
        tick();
        ifc.s_done = 0;
        chk("stray_L_phase", 32'(ifc.phase), 1);
        chk("stray_L_launch", 32'({ifc.l_start, ifc.s_start}), 0);
        ifc.l_done = 1;
        tick();
        ifc.l_done = 0; ifc.mix_done = 0;
        chk("both_done_phase", 32'(ifc.phase), 2);
        chk("both_done_sstart", 32'(ifc.s_start), 1);
        tick();
        ifc.start = 1; tick(); ifc.start = 0;
        chk("stray_S_phase", 32'(ifc.phase), 2);
        chk("stray_l_once", 32'(ls_cnt - l0), 1);
        chk("stray_s_once", 32'(ss_cnt - s0), 1);
        ifc.s_done = 1; tick(); ifc.s_done = 0;
        tick(); ifc.mix_done = 1; tick(); ifc.mix_done = 0;
        tick();

        // Reset mid-MIX_RUN with start and mix_done also high
        start_run();
        tick(); ifc.l_done = 1; tick(); ifc.l_done = 0;
        tick(); ifc.s_done = 1; tick(); ifc.s_done = 0;
        tick();
        chk("pre_rst_phase", 32'(ifc.phase), 3);
        d0 = done_cnt;
        ifc.mix_we = 1; ifc.mix_addr = 2'd1; ifc.mix_done = 1; ifc.start = 1; rst = 1;
        tick();
        chk("mrst_phase", 32'(ifc.phase), 0);
        chk("mrst_ready", 32'(ifc.ready), 1);
        chk("mrst_lram_we", 32'(ifc.lram_we), 0);
        rst = 0; ifc.mix_we = 0; ifc.mix_done = 0; ifc.start = 0;
        tick(); tick();
        chk("mrst_no_done", 32'(done_cnt - d0), 0);
        start_run();
        do_phase(1, 2); do_phase(2, 2); do_phase(3, 2);
        tick();
        chk("post_rst_done", 32'(done_cnt - d0), 1);
        chk("post_rst_idle", 32'(ifc.phase), 0);

        // l_done during the launch cycle is ignored
        start_run();
        ifc.l_done = 1; tick(); ifc.l_done = 0;
        chk("lc_stay", 32'(ifc.phase), 1);
        tick(); tick();
        chk("lc_still", 32'(ifc.phase), 1);
        ifc.l_done = 1; tick(); ifc.l_done = 0;
        chk("lc_adv", 32'(ifc.phase), 2);

`ifdef RC5_KEY_SCHED_TIMEOUT_EN
        // Finish this run, then let S_RUN expire
        tick(); ifc.s_done = 1; tick(); ifc.s_done = 0;
        tick(); ifc.mix_done = 1; tick(); ifc.mix_done = 0;
        tick();
        d0 = done_cnt;
        start_run();
        tick(); ifc.l_done = 1; tick(); ifc.l_done = 0;
        repeat (TMO - 1) tick();
        chk("tmo_last_cycle", 32'(ifc.phase), 2);
        chk("tmo_not_yet", 32'(ifc.timeout_err), 0);
        tick();
        chk("tmo_idle", 32'(ifc.phase), 0);
        chk("tmo_err", 32'(ifc.timeout_err), 1);
        tick();
        chk("tmo_sticky", 32'(ifc.timeout_err), 1);
        chk("tmo_no_done", 32'(done_cnt - d0), 0);
        start_run();
        chk("tmo_cleared", 32'(ifc.timeout_err), 0);
        do_phase(1, 1); do_phase(2, 1); do_phase(3, 1);
        chk("tmo_rerun_done", 32'(ifc.done), 1);
        tick();
`else
        // Without the watchdog S_RUN waits indefinitely
        repeat (40) tick();
        chk("nowd_wait", 32'(ifc.phase), 2);
        chk("nowd_err", 32'(ifc.timeout_err), 0);
        ifc.s_done = 1; tick(); ifc.s_done = 0;
        tick(); ifc.mix_done = 1; tick(); ifc.mix_done = 0;
        chk("nowd_finish", 32'(ifc.done), 1);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
